// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_DIGITS = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } b2b_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 converter: WIDTH-bit unsigned value to three BCD digits,
// one bit per clock, with results held in output registers between conversions.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_bin,
  output bcd_digit_t       o_hundreds,
  output bcd_digit_t       o_tens,
  output bcd_digit_t       o_ones,
  output logic             o_busy,
  output logic             o_valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SCR_W = 4 * BCD_DIGITS + WIDTH;

  // Three digits cap the representable value at 999, and hundreds is only 0..5 at 511.
  if (WIDTH < 1 || WIDTH > 9) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be in 1..9");
  end

  b2b_state_t       state_q, state_d;
  logic [SCR_W-1:0] scratch_q;
  logic [SCR_W-1:0] scratch_corr;
  logic [SCR_W-1:0] scratch_shf;
  logic [CNT_W-1:0] cnt_q;
  bcd_digit_t       hund_fix, tens_fix, ones_fix;
  logic             load;
  logic             done;

  bcd_add3 u_add3_hund (.din(scratch_q[WIDTH+8 +: 4]), .dout(hund_fix));
  bcd_add3 u_add3_tens (.din(scratch_q[WIDTH+4 +: 4]), .dout(tens_fix));
  bcd_add3 u_add3_ones (.din(scratch_q[WIDTH   +: 4]), .dout(ones_fix));

  assign scratch_corr = {hund_fix, tens_fix, ones_fix, scratch_q[WIDTH-1:0]};
  assign scratch_shf  = scratch_corr << 1;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = CONVERT;
          load    = 1'b1;
        end
      end
      CONVERT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      o_valid    <= 1'b0;
      o_hundreds <= '0;
      o_tens     <= '0;
      o_ones     <= '0;
    end else begin
      state_q <= state_d;
      o_valid <= done;
      if (load) begin
        cnt_q <= CNT_W'(WIDTH);
      end else if (state_q == CONVERT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (done) begin
        o_hundreds <= scratch_shf[WIDTH+8 +: 4];
        o_tens     <= scratch_shf[WIDTH+4 +: 4];
        o_ones     <= scratch_shf[WIDTH   +: 4];
      end
    end
  end

  // Scratch datapath: only meaningful while CONVERT, so it carries no reset
  always_ff @(posedge i_clk) begin
    if (load) begin
      scratch_q <= SCR_W'(i_bin);
    end else if (state_q == CONVERT) begin
      scratch_q <= scratch_shf;
    end
  end

  assign o_busy = (state_q == CONVERT);

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble). It takes an unsigned binary value and produces three BCD digits: hundreds, tens and ones. It sits directly upstream of the 7-segment decoder. Its digit outputs drive the decoder's `i_hundreds`, `i_tens` and `i_ones` inputs and hold steady between conversions, so the display never shows intermediate values.

## Interface
- `WIDTH`, default 8: bit width of the binary input. Legal range is 1..9, so the maximum value 511 fits in 3 digits. An out-of-range value is an elaboration error.

Ports (clock and reset first):
- `i_clk` — in — 1 — sole clock; all state changes on the rising edge.
- `i_rst` — in — 1 — reset, synchronous and active-high.
- `i_start` — in — 1 — conversion request; sampled at each rising edge.
- `i_bin` — in — WIDTH — unsigned value to convert; captured on the accepted start edge only.
- `o_hundreds` — out — 4 — BCD hundreds digit, 0..5.
- `o_tens` — out — 4 — BCD tens digit, 0..9.
- `o_ones` — out — 4 — BCD ones digit, 0..9.
- `o_busy` — out — 1 — high while a conversion is in progress.
- `o_valid` — out — 1 — one-cycle pulse; the digit outputs were updated on the preceding edge.

## Operation
- FSM states: IDLE and CONVERT.
- IDLE → CONVERT when `i_start`=1 at an edge:
  - `i_bin` is loaded into the low WIDTH bits of the scratch register.
  - The BCD field is cleared.
  - The shift counter is loaded with WIDTH.
- Scratch register is 12+WIDTH bits: `{bcd[11:0], bin[WIDTH-1:0]}`.
- CONVERT, each edge:
  - Every BCD nibble ≥5 gets +3; all three nibbles, including hundreds, are corrected in parallel.
  - Then the whole scratch register shifts left by 1.
  - The counter decrements.
- Last shift edge (counter reaches 1 before the edge):
  - The corrected-and-shifted BCD field is written to `o_hundreds`, `o_tens` and `o_ones`.
  - `o_valid` is set to 1.
  - The FSM returns to IDLE.
- `o_valid` clears on the next edge unless another conversion finishes then, which cannot happen.
- `i_start` while in CONVERT is ignored: no queueing, and `i_bin` is not re-sampled.
- Digit outputs change only on a completing edge. They hold the last result indefinitely otherwise.
- `o_busy` = (state == CONVERT), decoded from a register. No combinational path from `i_start`.
- Reset:
  - All outputs go to 0 and the state goes to IDLE.
  - Reset mid-conversion aborts it: no `o_valid` is produced and the digits read 0,0,0.
  - `i_rst` dominates `i_start` on the same edge.

## Timing
- Start accepted at edge E0. `o_busy`=1 from after E0 through the cycle before E(WIDTH).
- Results and `o_valid`=1 are visible after edge E(WIDTH). Latency is WIDTH cycles (8 at default).
- Throughput: a new `i_start` is accepted in the same cycle `o_valid` is high, because the FSM is already IDLE. Back-to-back rate is one conversion per WIDTH+1 edges when `i_start` is held high continuously.
- `i_start` held high in IDLE re-triggers on every return to IDLE. It is a level request, not edge-detected.

## Structure
- Package `bcd_pkg`:
  - typedef `bcd_digit_t` (logic [3:0]).
  - Constant `BCD_DIGITS` = 3.
  - Enum `b2b_state_t` {IDLE, CONVERT}.
- Sub-module `bcd_add3`: combinational, 4-bit in and 4-bit out; adds 3 when the input is ≥5. Instantiated three times.
- Top contains the scratch register, the counter ($clog2(WIDTH+1) bits), the FSM and the output registers.

## Test plan
- Reset, then `i_bin`=0 with `i_start` pulsed → after 8 edges `o_valid`=1 for exactly one cycle; digits 0,0,0; `o_busy` high for 8 cycles.
- `i_bin`=255 → digits 2,5,5. Then `i_bin`=99 → 0,9,9. Then `i_bin`=128 → 1,2,8. Digits hold between runs.
- Start 200; pulse `i_start` with `i_bin`=13 at cycle 3 of the conversion → result 2,0,0; only one `o_valid`; the second request is lost.
- Start 255; assert `i_rst` at cycle 4 → digits 0,0,0, `o_busy`=0, and no `o_valid` afterwards.
- Hold `i_start`=1 with `i_bin` changing 7 → 42 per accept → `o_valid` pulses every 9 edges; results 0,0,7 then 0,4,2.
- WIDTH=9, `i_bin`=511 → digits 5,1,1 after 9 edges. Also sweep all 0..511 against a reference model.
